// File: rtl/mixer_pkg.sv
// mixer_pkg: shared constants, FSM state type and restoring-divide step for the note mixer
package mixer_pkg;
   localparam int NUM_NOTES = 13;
   localparam int NOTE_W = 8;
   localparam int SAMPLE_DIV = 227;
   localparam int ACC_W = 12;
   localparam int CNT_W = 4;
   typedef enum logic [2:0] {IDLE, SUM, DIV, DIV_WAIT, OUT} mix_state_t;
   function automatic logic [CNT_W+ACC_W-1:0] div_step(input logic [CNT_W-1:0] rem,
                                                      input logic [ACC_W-1:0] q,
                                                      input logic [CNT_W-1:0] d);
      logic [CNT_W:0] r;
      r = {rem, q[ACC_W-1]};
      return (r >= {1'b0, d}) ? {CNT_W'(r - {1'b0, d}), q[ACC_W-2:0], 1'b1}
                              : {r[CNT_W-1:0], q[ACC_W-2:0], 1'b0};
   endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle, done pulses ACC_W cycles after start
module seq_divider
   import mixer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ACC_W-1:0] dividend,
   input  logic [CNT_W-1:0] divisor,
   output logic [ACC_W-1:0] quotient,
   output logic             done
);
   logic [CNT_W-1:0] rem, d;
   logic [3:0]       n;
   always_ff @(posedge clk) begin
      if (rst) begin
         rem      <= '0;
         d        <= '0;
         n        <= '0;
         quotient <= '0;
         done     <= 1'b0;
      end else if (start) begin
         {rem, quotient} <= div_step('0, dividend, divisor);
         d               <= divisor;
         n               <= 4'(ACC_W - 1);
         done            <= 1'b0;
      end else begin
         if (n != 4'd0) {rem, quotient} <= div_step(rem, quotient, d);
         n    <= (n != 4'd0) ? n - 4'd1 : n;
         done <= n == 4'd1;
      end
   end
endmodule

// File: rtl/mix_sequencer.sv
// mix_sequencer: per-sample snapshot, serial sum and active-note count, shared divider for the average
module mix_sequencer #(
   parameter int NUM_NOTES  = mixer_pkg::NUM_NOTES,
   parameter int NOTE_W     = mixer_pkg::NOTE_W,
   parameter int SAMPLE_DIV = mixer_pkg::SAMPLE_DIV
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [NUM_NOTES*NOTE_W-1:0] notes,
   output logic                        sample_tick,
   output logic [NOTE_W-1:0]           mixed_sample,
   output logic                        sample_valid,
   output logic                        busy,
   output logic                        overrun
);
   import mixer_pkg::*;
   localparam int TW = $clog2(SAMPLE_DIV);
   mix_state_t                  state;
   logic [TW-1:0]               tick_cnt;
   logic [NUM_NOTES*NOTE_W-1:0] snap;
   logic [ACC_W-1:0]            acc, quotient;
   logic [CNT_W-1:0]            cnt, idx;
   logic [NOTE_W-1:0]           cur;
   logic                        start, done;
   assign sample_tick = en && tick_cnt == TW'(SAMPLE_DIV - 1);
   assign busy        = state != IDLE;
   assign cur         = snap[idx*NOTE_W +: NOTE_W];
   assign start       = state == DIV && cnt != '0;
   always_ff @(posedge clk) begin
      if (rst) tick_cnt <= '0;
      else if (en) tick_cnt <= (tick_cnt == TW'(SAMPLE_DIV - 1)) ? '0 : tick_cnt + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         snap         <= '0;
         acc          <= '0;
         cnt          <= '0;
         idx          <= '0;
         mixed_sample <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (sample_tick && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE: if (sample_tick) begin
               snap  <= notes;
               acc   <= '0;
               cnt   <= '0;
               idx   <= '0;
               state <= SUM;
            end
            SUM: begin
               acc   <= acc + ACC_W'(cur);
               cnt   <= cnt + CNT_W'(cur != '0);
               idx   <= idx + 1'b1;
               state <= (idx == CNT_W'(NUM_NOTES - 1)) ? DIV : SUM;
            end
            DIV: if (cnt == '0) begin
               mixed_sample <= '0;
               sample_valid <= 1'b1;
               state        <= OUT;
            end else state <= DIV_WAIT;
            DIV_WAIT: if (done) begin
               mixed_sample <= quotient[NOTE_W-1:0];
               sample_valid <= 1'b1;
               state        <= OUT;
            end
            default: state <= IDLE;
         endcase
      end
   end
   seq_divider u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dividend (acc),
      .divisor  (cnt),
      .quotient (quotient),
      .done     (done)
   );
endmodule

// File: tb/tb_mix_sequencer.sv
// tb_mix_sequencer: directed scoreboard bench for the note mixer (default and short sample period)
module tb_mix_sequencer;
   localparam int NN = 13;
   typedef struct {logic [7:0] v; int cyc;} exp_t;
   logic          clk = 0, rst0 = 1, en0 = 0, rst1 = 1, en1 = 0;
   logic [NN*8-1:0] notes0 = '0, notes1 = '0;
   logic          tick0, valid0, busy0, ovr0, tick1, valid1, busy1, ovr1;
   logic [7:0]    mix0, mix1;
   int            cyc = 0, total = 0, passed = 0;
   exp_t          sb[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   mix_sequencer u_d0 (.clk(clk), .rst(rst0), .en(en0), .notes(notes0), .sample_tick(tick0),
      .mixed_sample(mix0), .sample_valid(valid0), .busy(busy0), .overrun(ovr0));
   mix_sequencer #(.SAMPLE_DIV(20)) u_d1 (.clk(clk), .rst(rst1), .en(en1), .notes(notes1),
      .sample_tick(tick1), .mixed_sample(mix1), .sample_valid(valid1), .busy(busy1), .overrun(ovr1));
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask
   function automatic logic [NN*8-1:0] mk(input int a, input int b, input int c);
      logic [NN*8-1:0] n = '0;
      n[8 +: 8]  = 8'(a);
      n[16 +: 8] = 8'(b);
      n[24 +: 8] = 8'(c);
      return n;
   endfunction
   function automatic exp_t model(input logic [NN*8-1:0] n, input int t);
      int s = 0, c = 0;
      exp_t e;
      for (int k = 0; k < NN; k++) begin
         s += int'(n[k*8 +: 8]);
         c += (n[k*8 +: 8] != 0) ? 1 : 0;
      end
      e.v   = (c != 0) ? 8'(s / c) : 8'd0;
      e.cyc = t + ((c != 0) ? 27 : 15);
      return e;
   endfunction
   always @(negedge clk) begin : mon
      exp_t e;
      if (valid0) begin
         if (sb.size() == 0) check("unexpected_valid", 32'(valid0), 0);
         else begin
            e = sb.pop_front();
            check("mixed_sample", 32'(mix0), 32'(e.v));
            check("latency", cyc, e.cyc);
         end
      end
   end
   task automatic wait_tick(input bit which, output int t);
      t = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (which ? tick1 : tick0) begin
            t = cyc;
            break;
         end
      end
      check("tick_seen", 32'(t >= 0), 1);
   endtask
   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      check("drain", sb.size(), 0);
   endtask
   task automatic run(input logic [NN*8-1:0] v);
      int t;
      notes0 = v;
      wait_tick(0, t);
      sb.push_back(model(v, t));
      drain();
   endtask
   initial begin
      int t, r, nv, vcyc, ocyc, nt;
      logic [7:0] vval;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(valid0), 0);
      check("rst_mix", 32'(mix0), 0);
      check("rst_busy", 32'(busy0), 0);
      check("rst_ovr", 32'(ovr0), 0);
      check("rst_tick", 32'(tick0), 0);
      rst0 = 0;
      en0  = 1;
      run('0);
      run(mk(200, 100, 0));
      run('1);
      notes0 = mk(1, 2, 2);
      wait_tick(0, t);
      sb.push_back(model(mk(1, 2, 2), t));
      @(negedge clk);
      @(negedge clk);
      notes0 = '1;
      drain();
      notes0 = mk(200, 100, 0);
      wait_tick(0, t);
      repeat (20) @(negedge clk);
      check("busy_div_wait", 32'(busy0), 1);
      rst0 = 1;
      @(negedge clk);
      check("abort_busy", 32'(busy0), 0);
      check("abort_mix", 32'(mix0), 0);
      check("abort_valid", 32'(valid0), 0);
      rst0 = 0;
      r = cyc;
      notes0 = mk(10, 20, 30);
      wait_tick(0, t);
      check("tick_after_rst", t, r + 226);
      sb.push_back(model(mk(10, 20, 30), t));
      drain();
      notes0 = mk(0, 0, 7);
      wait_tick(0, t);
      sb.push_back(model(notes0, t));
      @(negedge clk);
      en0 = 0;
      drain();
      nt = 0;
      repeat (300) begin
         @(negedge clk);
         if (tick0) nt++;
      end
      check("en0_no_ticks", nt, 0);
      check("ovr0_clear", 32'(ovr0), 0);
      notes1 = mk(60, 30, 0);
      en1  = 1;
      rst1 = 0;
      r = cyc;
      wait_tick(1, t);
      check("d1_first_tick", t, r + 19);
      nv = 0; vcyc = -1; ocyc = -1; vval = '0;
      repeat (60) begin
         @(negedge clk);
         if (valid1) begin
            nv++;
            vcyc = cyc;
            vval = mix1;
         end
         if (ovr1 && ocyc < 0) ocyc = cyc;
      end
      check("d1_valid_count", nv, 1);
      check("d1_latency", vcyc, t + 27);
      check("d1_value", 32'(vval), 45);
      check("d1_overrun_cyc", ocyc, t + 21);
      en1 = 0;
      nv = 0; nt = 0; vval = '0;
      repeat (60) begin
         @(negedge clk);
         if (tick1) nt++;
         if (valid1) begin
            nv++;
            vval = mix1;
         end
      end
      check("d1_en0_ticks", nt, 0);
      check("d1_inflight_done", nv, 1);
      check("d1_inflight_value", 32'(vval), 45);
      check("d1_overrun_sticky", 32'(ovr1), 1);
      check("d1_idle", 32'(busy1), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
